// File: rtl/flow_flag_store_if.sv
// Bundle of the flag-store ports: set/clear/new-flow strobes, read request/response
// and the pending-flow scanner handshake.
interface flow_flag_store_if #(
    parameter int unsigned NUM_FLOWS     = 64,
    parameter int unsigned FLOWID_W      = $clog2(NUM_FLOWS),
    parameter int unsigned NUM_FLAGS     = 2,
    parameter int unsigned NUM_SET_PORTS = 2
);
    logic                               new_flow_val;
    logic [FLOWID_W-1:0]                new_flow_flowid;
    logic [NUM_SET_PORTS-1:0]           set_val;
    logic [NUM_SET_PORTS*FLOWID_W-1:0]  set_flowid;
    logic [NUM_SET_PORTS*NUM_FLAGS-1:0] set_mask;
    logic                               clr_val;
    logic [FLOWID_W-1:0]                clr_flowid;
    logic [NUM_FLAGS-1:0]               clr_mask;
    logic                               rd_req_val;
    logic [FLOWID_W-1:0]                rd_req_flowid;
    logic                               rd_req_clr;
    logic                               rd_req_rdy;
    logic                               rd_resp_val;
    logic [FLOWID_W-1:0]                rd_resp_flowid;
    logic [NUM_FLAGS-1:0]               rd_resp_flags;
    logic                               rd_resp_rdy;
    logic                               scan_val;
    logic [FLOWID_W-1:0]                scan_flowid;
    logic [NUM_FLAGS-1:0]               scan_flags;
    logic                               scan_rdy;

    modport slave (
        input  new_flow_val, new_flow_flowid, set_val, set_flowid, set_mask,
               clr_val, clr_flowid, clr_mask, rd_req_val, rd_req_flowid, rd_req_clr,
               rd_resp_rdy, scan_rdy,
        output rd_req_rdy, rd_resp_val, rd_resp_flowid, rd_resp_flags,
               scan_val, scan_flowid, scan_flags
    );

    modport master (
        output new_flow_val, new_flow_flowid, set_val, set_flowid, set_mask,
               clr_val, clr_flowid, clr_mask, rd_req_val, rd_req_flowid, rd_req_clr,
               rd_resp_rdy, scan_rdy,
        input  rd_req_rdy, rd_resp_val, rd_resp_flowid, rd_resp_flags,
               scan_val, scan_flowid, scan_flags
    );
endinterface

// File: rtl/flow_flag_store.sv
// Per-flow event-flag store: multi-port set, masked clear, read-and-clear response
// pipe, and a round-robin scanner presenting the next flow with pending flags.
module flow_flag_store #(
    parameter int unsigned          NUM_FLOWS     = 64,
    parameter int unsigned          FLOWID_W      = $clog2(NUM_FLOWS),
    parameter int unsigned          NUM_FLAGS     = 2,
    parameter int unsigned          NUM_SET_PORTS = 2,
    parameter logic [NUM_FLAGS-1:0] SCAN_MASK     = {NUM_FLAGS{1'b1}}
) (
    input logic              clk,
    input logic              rst,
    flow_flag_store_if.slave bus
);
    typedef logic [FLOWID_W-1:0]  flowid_t;
    typedef logic [NUM_FLAGS-1:0] flags_t;

    flags_t  flags_q [NUM_FLOWS];
    flags_t  flags_d [NUM_FLOWS];

    logic    rd_val_q;
    logic    rd_clr_q;
    flowid_t rd_flowid_q;

    logic    scan_val_q;
    flowid_t scan_flowid_q;
    flags_t  scan_flags_q;
    flowid_t scan_ptr_q;

    logic    rd_req_rdy;
    logic    rd_accept;
    logic    scan_accept;
    logic    scan_load;
    flowid_t scan_next_ptr;
    flowid_t scan_start;
    flowid_t cand_flowid;
    logic    cand_found;

    assign rd_req_rdy = bus.rd_resp_rdy | ~rd_val_q;
    assign rd_accept  = rd_val_q & bus.rd_resp_rdy;

    // A set survives a same-cycle read-clear; clear and new-flow override sets.
    always_comb begin
        for (int f = 0; f < int'(NUM_FLOWS); f++) begin
            flags_t set_acc;
            flags_t clr_term;
            flags_t rdclr_term;
            flags_t nf_term;
            set_acc = '0;
            for (int p = 0; p < int'(NUM_SET_PORTS); p++) begin
                if (bus.set_val[p] &&
                    bus.set_flowid[p*FLOWID_W +: FLOWID_W] == flowid_t'(f)) begin
                    set_acc = set_acc | bus.set_mask[p*NUM_FLAGS +: NUM_FLAGS];
                end
            end
            rdclr_term = (rd_accept && rd_clr_q && rd_flowid_q == flowid_t'(f)) ? '1 : '0;
            clr_term   = (bus.clr_val && bus.clr_flowid == flowid_t'(f)) ? bus.clr_mask : '0;
            nf_term    = (bus.new_flow_val && bus.new_flow_flowid == flowid_t'(f)) ? '1 : '0;
            flags_d[f] = ((flags_q[f] & ~rdclr_term) | set_acc) & ~clr_term & ~nf_term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '{default: '0};
        end else begin
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_val_q    <= 1'b0;
            rd_clr_q    <= 1'b0;
            rd_flowid_q <= '0;
        end else if (rd_req_rdy) begin
            rd_val_q    <= bus.rd_req_val;
            rd_clr_q    <= bus.rd_req_clr;
            rd_flowid_q <= bus.rd_req_flowid;
        end
    end

    assign bus.rd_req_rdy     = rd_req_rdy;
    assign bus.rd_resp_val    = rd_val_q;
    assign bus.rd_resp_flowid = rd_flowid_q;
    assign bus.rd_resp_flags  = (32'(rd_flowid_q) < NUM_FLOWS) ? flags_q[rd_flowid_q] : '0;

    assign scan_accept   = scan_val_q & bus.scan_rdy;
    assign scan_load     = ~scan_val_q | bus.scan_rdy;
    assign scan_next_ptr = (scan_flowid_q == flowid_t'(NUM_FLOWS - 1)) ? '0
                                                                       : scan_flowid_q + 1'b1;
    // Search from the post-accept pointer so an accepted flow is not re-presented at once.
    assign scan_start    = scan_accept ? scan_next_ptr : scan_ptr_q;

    always_comb begin
        cand_found  = 1'b0;
        cand_flowid = '0;
        for (int i = 0; i < int'(NUM_FLOWS); i++) begin
            int idx;
            idx = int'(scan_start) + i;
            if (idx >= int'(NUM_FLOWS)) begin
                idx = idx - int'(NUM_FLOWS);
            end
            if (!cand_found && |(flags_q[flowid_t'(idx)] & SCAN_MASK)) begin
                cand_found  = 1'b1;
                cand_flowid = flowid_t'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_val_q    <= 1'b0;
            scan_flowid_q <= '0;
            scan_flags_q  <= '0;
            scan_ptr_q    <= '0;
        end else begin
            if (scan_accept) begin
                scan_ptr_q <= scan_next_ptr;
            end
            if (scan_load) begin
                scan_val_q    <= cand_found;
                scan_flowid_q <= cand_flowid;
                scan_flags_q  <= flags_q[cand_flowid];
            end
        end
    end

    assign bus.scan_val    = scan_val_q;
    assign bus.scan_flowid = scan_flowid_q;
    assign bus.scan_flags  = scan_flags_q;
endmodule

// File: doc/flow_flag_store.md
# flow_flag_store

Per-flow multi-bit event-flag store for the send pipe, generalising the two-flag retransmit/timeout store to NUM_FLAGS flags, multiple set sources, read-and-clear, and a round-robin pending-flow scanner. Timer, ACK and app-side producers set flags. The main pipe reads and clears them. The scanner gives the scheduler the next flow with pending work, without polling every flow ID.

## Interface
Parameters:
- NUM_FLOWS, 64: number of flows; any value ≥2, not required to be a power of 2.
- FLOWID_W, $clog2(NUM_FLOWS): flow ID width.
- NUM_FLAGS, 2: flags per flow.
- NUM_SET_PORTS, 2: independent set sources.
- SCAN_MASK, {NUM_FLAGS{1'b1}}: flags that make a flow eligible for the scanner.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- new_flow_val  in  1  clears all flags of new_flow_flowid
- new_flow_flowid  in  FLOWID_W  flow being (re)initialised
- set_val  in  NUM_SET_PORTS  per-port set strobe
- set_flowid  in  NUM_SET_PORTS*FLOWID_W  per-port target flow
- set_mask  in  NUM_SET_PORTS*NUM_FLAGS  per-port flags to set
- clr_val  in  1  explicit clear strobe
- clr_flowid  in  FLOWID_W  flow to clear
- clr_mask  in  NUM_FLAGS  flags to clear
- rd_req_val  in  1  read request valid
- rd_req_flowid  in  FLOWID_W  flow to read
- rd_req_clr  in  1  clear the returned flags when the response is accepted
- rd_req_rdy  out  1  = rd_resp_rdy | ~rd_resp_val
- rd_resp_val  out  1  response valid
- rd_resp_flowid  out  FLOWID_W  flow ID of the response
- rd_resp_flags  out  NUM_FLAGS  flag state of that flow
- rd_resp_rdy  in  1  consumer accepts the response
- scan_val  out  1  a pending flow is presented
- scan_flowid  out  FLOWID_W  presented flow
- scan_flags  out  NUM_FLAGS  that flow's flags at capture time
- scan_rdy  in  1  scheduler accepts the presented flow

## Operation
- Storage: flags_reg[NUM_FLOWS][NUM_FLAGS], flops. Every bit resets to 0.
- Update order for each flow f and flag b, all terms from the same cycle:
  - next = ((reg & ~rdclr) | set) & ~clr & ~newflow.
  - rdclr: an accepted read response with its clr bit set, for flow f. Covers all flags.
  - set: the OR over every set port targeting f.
  - clr: the explicit clear, masked by clr_mask.
  - newflow: new_flow_val for f. Covers all flags.
- Resulting priority: new_flow > explicit clr > set > read-clear.
  - A set arriving in the same cycle as a read-clear of the same flow survives, so the event is not lost.
  - Any number of set ports may hit the same flow in one cycle; their masks OR together.
- Read port: a one-entry pipeline register holding val, flowid and clr.
  - Loads when rd_req_rdy is high.
  - rd_resp_flags is a combinational read of flags_reg at the registered flowid. It tracks updates while the response is held un-accepted.
  - The read-clear takes effect only in the cycle where rd_resp_val & rd_resp_rdy.
- Scanner:
  - Holds scan_ptr. Each cycle it combinationally finds the first flow f, from scan_ptr upward with wrap at NUM_FLOWS-1 → 0, where (flags_reg[f] & SCAN_MASK) != 0.
  - Output stage is registered. It loads the candidate (or scan_val=0 if none) whenever the stage is empty or scan_rdy is high.
  - While scan_val & ~scan_rdy, scan_flowid and scan_flags are held stable.
  - On accept, scan_ptr <= (scan_flowid == NUM_FLOWS-1) ? 0 : scan_flowid + 1.
  - The scanner never modifies flags. A presented entry may be stale, because the flow may have been cleared after capture. The consumer resolves this with a read.

## Timing
- Reset values: rd_resp_val 0, rd_resp_flowid 0, scan_val 0, scan_flowid 0, scan_flags 0, scan_ptr 0, all flags 0. rd_req_rdy=1 in the first cycle after reset.
- Set, clear and new_flow strobed in cycle t appear in flags_reg, and therefore in rd_resp_flags, at t+1.
- Read latency: request accepted at t → rd_resp_val at t+1. Full throughput of one read per cycle while rd_resp_rdy=1.
- Scanner latency: a flag set at t is visible to the search at t+1 and is presented on scan_* at t+2 at the earliest. Throughput is one accepted flow per cycle.
- Back-to-back read-clear of the same flow: the second response reflects the first clear and shows 0 unless re-set.
- Reset asserted mid-operation discards any held read response and scanner entry. No flag state survives.

## Test plan
- Set port 0 sets flow 5 mask 2'b01 and port 1 sets flow 5 mask 2'b10 in the same cycle; then read flow 5 → rd_resp_flags=2'b11 one cycle after the request.
- clr_val on flow 3 mask 2'b11 and a set on flow 3 mask 2'b01 in the same cycle → flags[3]=0. Read-clear of flow 3 accepted in the same cycle as a set 2'b10 → flags[3]=2'b10.
- Hold rd_resp_rdy=0 for 3 cycles with a read of flow 7 pending → rd_req_rdy=0 and the response is held. Set flow 7 during the stall → rd_resp_flags updates. The clear happens only on accept.
- Flows 2, 9 and 63 pending, NUM_FLOWS=64, scan_rdy=1 → scanner presents 2, 9, 63, then wraps to 2 while the flags stay set. With scan_rdy=0, flowid 2 is held stable.
- new_flow on flow 9 while flags[9]=2'b11 and a set on flow 9 in the same cycle → flags[9]=0. The scanner skips 9 on its next search.
- Reset pulsed with rd_resp_val=1 and scan_val=1 → next cycle both outputs are 0, scan_ptr=0, and a read of any flow returns 0.
